pixels_sequencer: RTL and testbench

Parametrised pixel-window sequencer for the image input buffer. After each buffer load it steps the buffer's pixel-select mux through `NUM_WIN` windows, one per completed calculation. It gates the downstream calculation unit, and reports sequence completion and preemption. It supports stall (`hold`), continuous looping, and back-to-back loads without losing a load request.

---
 rtl/pixels_sequencer.sv | 103 ++++++++++
 tb/tb_pixels_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pixels_sequencer.sv
// Pixel-window sequencer: after each buffer load, steps the pixel-select mux
// through NUM_WIN windows, one per completed calculation, gating the calc unit.
module pixels_sequencer #(
    parameter int NUM_WIN = 4,
    parameter int SEL_W   = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load_enable,
    input  logic             calc_done,
    input  logic             hold,
    input  logic             loop_mode,
    output logic [SEL_W-1:0] select,
    output logic             calc_enable,
    output logic             busy,
    output logic             seq_done,
    output logic             abort
);

    generate
        if (NUM_WIN < 2 || NUM_WIN > 255 || (2 ** SEL_W) <= NUM_WIN) begin : g_param_check
            $error("pixels_sequencer: NUM_WIN must be 2..255 and fit in SEL_W bits");
        end
    endgenerate

    localparam logic [SEL_W-1:0] LAST_WIN  = SEL_W'(NUM_WIN);
    localparam logic [SEL_W-1:0] FIRST_WIN = SEL_W'(1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t           state, state_n;
    logic [SEL_W-1:0] win, win_n;
    logic             seq_done_n, abort_n;
    logic             accept;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            win      <= '0;
            seq_done <= 1'b0;
            abort    <= 1'b0;
        end else begin
            state    <= state_n;
            win      <= win_n;
            seq_done <= seq_done_n;
            abort    <= abort_n;
        end
    end

    // A calc_done seen while held is dropped, never queued.
    assign accept = calc_done & ~hold;

    always_comb begin
        state_n    = state;
        win_n      = win;
        seq_done_n = 1'b0;
        abort_n    = 1'b0;
        case (state)
            IDLE: begin
                if (load_enable) begin
                    state_n = ACTIVE;
                    win_n   = FIRST_WIN;
                end
            end
            ACTIVE: begin
                if (win == LAST_WIN) begin
                    // Completion wins over a simultaneous load; the load only decides restart vs idle.
                    if (accept) begin
                        seq_done_n = 1'b1;
                        if (load_enable || loop_mode) begin
                            win_n = FIRST_WIN;
                        end else begin
                            state_n = IDLE;
                            win_n   = '0;
                        end
                    end else if (load_enable) begin
                        win_n   = FIRST_WIN;
                        abort_n = 1'b1;
                    end
                end else begin
                    if (accept) begin
                        win_n = win + 1'b1;
                    end else if (load_enable) begin
                        win_n   = FIRST_WIN;
                        abort_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                win_n   = '0;
            end
        endcase
    end

    assign busy        = (state == ACTIVE);
    assign select      = busy ? win : '0;
    assign calc_enable = busy & ~hold;

endmodule

// File: tb/tb_pixels_sequencer.sv
// Bench for pixels_sequencer: vector table on a NUM_WIN=4 instance plus
// hand-written sequences on a NUM_WIN=6 instance, checked through a scoreboard queue.
module tb_pixels_sequencer;

    typedef struct {
        logic [3:0] in;
        logic [2:0] sel;
        logic [3:0] out;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, le_a, cd_a, hd_a, lp_a;
    logic [2:0] sel_a;
    logic       ce_a, busy_a, done_a, abort_a;

    logic       rst_b, le_b, cd_b, hd_b, lp_b;
    logic [2:0] sel_b;
    logic       ce_b, busy_b, done_b, abort_b;

    pixels_sequencer #(.NUM_WIN(4), .SEL_W(3)) dut_a (
        .clk(clk), .n_rst(rst_a), .load_enable(le_a), .calc_done(cd_a),
        .hold(hd_a), .loop_mode(lp_a), .select(sel_a), .calc_enable(ce_a),
        .busy(busy_a), .seq_done(done_a), .abort(abort_a)
    );

    pixels_sequencer #(.NUM_WIN(6), .SEL_W(3)) dut_b (
        .clk(clk), .n_rst(rst_b), .load_enable(le_b), .calc_done(cd_b),
        .hold(hd_b), .loop_mode(lp_b), .select(sel_b), .calc_enable(ce_b),
        .busy(busy_b), .seq_done(done_b), .abort(abort_b)
    );

    int         total = 0;
    int         bad   = 0;
    logic [6:0] exp_q[$];
    vec_t       vecs[$];

    // in = {load_enable, calc_done, hold, loop_mode}; out = {calc_enable, busy, seq_done, abort}
    function automatic vec_t mk(input logic [3:0] in, input logic [2:0] sel, input logic [3:0] out);
        vec_t v;
        v.in  = in;
        v.sel = sel;
        v.out = out;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [6:0] act);
        logic [6:0] want;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s: no expected entry queued, got %b", name, act);
        end else begin
            want = exp_q.pop_front();
            if (act !== want) begin
                bad++;
                $display("[TB] FAIL %s: got {sel,ce,busy,done,abort}=%b want %b", name, act, want);
            end
        end
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        @(negedge clk);
        {le_a, cd_a, hd_a, lp_a} = v.in;
        exp_q.push_back({v.sel, v.out});
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d", idx), {sel_a, ce_a, busy_a, done_a, abort_a});
    endtask

    task automatic stepB(input string name, input logic le, input logic cd, input logic [6:0] want);
        @(negedge clk);
        le_b = le;
        cd_b = cd;
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        checkOutput(name, {sel_b, ce_b, busy_b, done_b, abort_b});
    endtask

    initial begin
        {le_a, cd_a, hd_a, lp_a} = 4'b0000;
        {le_b, cd_b, hd_b, lp_b} = 4'b0000;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        exp_q.push_back(7'b000_0000);
        checkOutput("reset_a", {sel_a, ce_a, busy_a, done_a, abort_a});
        exp_q.push_back(7'b000_0000);
        checkOutput("reset_b", {sel_b, ce_b, busy_b, done_b, abort_b});
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // basic run with calc_done every third cycle, then idle ignores calc_done/hold
        vecs.push_back(mk(4'b1000, 3'd1, 4'b1100));
        vecs.push_back(mk(4'b0000, 3'd1, 4'b1100));
        vecs.push_back(mk(4'b0000, 3'd1, 4'b1100));
        vecs.push_back(mk(4'b0100, 3'd2, 4'b1100));
        vecs.push_back(mk(4'b0000, 3'd2, 4'b1100));
        vecs.push_back(mk(4'b0000, 3'd2, 4'b1100));
        vecs.push_back(mk(4'b0100, 3'd3, 4'b1100));
        vecs.push_back(mk(4'b0000, 3'd3, 4'b1100));
        vecs.push_back(mk(4'b0000, 3'd3, 4'b1100));
        vecs.push_back(mk(4'b0100, 3'd4, 4'b1100));
        vecs.push_back(mk(4'b0000, 3'd4, 4'b1100));
        vecs.push_back(mk(4'b0000, 3'd4, 4'b1100));
        vecs.push_back(mk(4'b0100, 3'd0, 4'b0010));
        vecs.push_back(mk(4'b0000, 3'd0, 4'b0000));
        vecs.push_back(mk(4'b0100, 3'd0, 4'b0000));
        vecs.push_back(mk(4'b0010, 3'd0, 4'b0000));
        // preemption, restart at window 1, calc_done beating load_enable
        vecs.push_back(mk(4'b1000, 3'd1, 4'b1100));
        vecs.push_back(mk(4'b0100, 3'd2, 4'b1100));
        vecs.push_back(mk(4'b0100, 3'd3, 4'b1100));
        vecs.push_back(mk(4'b1000, 3'd1, 4'b1101));
        vecs.push_back(mk(4'b0000, 3'd1, 4'b1100));
        vecs.push_back(mk(4'b1000, 3'd1, 4'b1101));
        vecs.push_back(mk(4'b0100, 3'd2, 4'b1100));
        vecs.push_back(mk(4'b1100, 3'd3, 4'b1100));
        vecs.push_back(mk(4'b0100, 3'd4, 4'b1100));
        // final-window collision
        vecs.push_back(mk(4'b1100, 3'd1, 4'b1110));
        vecs.push_back(mk(4'b0000, 3'd1, 4'b1100));
        // load while held, calc_done dropped while held, load in last window
        vecs.push_back(mk(4'b1010, 3'd1, 4'b0101));
        vecs.push_back(mk(4'b0110, 3'd1, 4'b0100));
        vecs.push_back(mk(4'b0100, 3'd2, 4'b1100));
        vecs.push_back(mk(4'b0100, 3'd3, 4'b1100));
        vecs.push_back(mk(4'b0100, 3'd4, 4'b1100));
        vecs.push_back(mk(4'b1000, 3'd1, 4'b1101));
        // loop mode with calc_done held high
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(mk(4'b0101, 3'd2, 4'b1100));
            vecs.push_back(mk(4'b0101, 3'd3, 4'b1100));
            vecs.push_back(mk(4'b0101, 3'd4, 4'b1100));
            vecs.push_back(mk(4'b0101, 3'd1, 4'b1110));
        end
        for (int h = 0; h < 5; h++) begin
            vecs.push_back(mk(4'b0111, 3'd1, 4'b0100));
        end
        vecs.push_back(mk(4'b0101, 3'd2, 4'b1100));
        vecs.push_back(mk(4'b0101, 3'd3, 4'b1100));
        vecs.push_back(mk(4'b0101, 3'd4, 4'b1100));
        vecs.push_back(mk(4'b0101, 3'd1, 4'b1110));
        vecs.push_back(mk(4'b0100, 3'd2, 4'b1100));
        vecs.push_back(mk(4'b0100, 3'd3, 4'b1100));
        vecs.push_back(mk(4'b0100, 3'd4, 4'b1100));
        vecs.push_back(mk(4'b0100, 3'd0, 4'b0010));
        vecs.push_back(mk(4'b0000, 3'd0, 4'b0000));

        foreach (vecs[i]) begin
            applyStimulus(i, vecs[i]);
        end

        // six-window instance: full sequence with calc_done held high
        stepB("b_load", 1'b1, 1'b0, {3'd1, 4'b1100});
        for (int k = 2; k <= 6; k++) begin
            stepB($sformatf("b_win%0d", k), 1'b0, 1'b1, {3'(k), 4'b1100});
        end
        stepB("b_done", 1'b0, 1'b1, {3'd0, 4'b0010});
        stepB("b_idle", 1'b0, 1'b0, {3'd0, 4'b0000});

        // reset in window 5 must clear outputs without a clock edge
        stepB("b_reload", 1'b1, 1'b0, {3'd1, 4'b1100});
        for (int k = 2; k <= 5; k++) begin
            stepB($sformatf("b_run%0d", k), 1'b0, 1'b1, {3'(k), 4'b1100});
        end
        @(negedge clk);
        cd_b = 1'b0;
        #1;
        rst_b = 1'b0;
        #1;
        exp_q.push_back(7'b000_0000);
        checkOutput("b_async_reset", {sel_b, ce_b, busy_b, done_b, abort_b});
        @(negedge clk);
        rst_b = 1'b1;
        stepB("b_after_reset", 1'b0, 1'b1, {3'd0, 4'b0000});
        stepB("b_restart", 1'b1, 1'b0, {3'd1, 4'b1100});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
